dcache_controller: RTL and testbench

//   Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and off-chip data memory.

---
 rtl/dcache_controller_pkg.sv | 50 +++++
 rtl/dcache_controller_if.sv | 31 +++
 rtl/dcache_controller_sram.sv | 66 ++++++
 rtl/dcache_controller.sv | 180 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared types and geometry for the direct-mapped write-back L1 data cache.
//   Address split: [31:10] tag, [9:5] index, [4:2] word select, [1:0] byte offset.
//   Helpers read or replace one 32-bit word inside a 256-bit line.
package dcache_controller_pkg;

    localparam int unsigned LINES      = 32;
    localparam int unsigned BLOCK_BITS = 256;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned WORDS      = 8;
    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned TAG_W      = 22;
    localparam int unsigned WSEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef logic [BLOCK_BITS-1:0] line_t;
    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [INDEX_W-1:0]    index_t;
    typedef logic [WSEL_W-1:0]     wsel_t;
    typedef logic [WORD_W-1:0]     word_t;

    // CPU byte address viewed as cache fields
    typedef struct packed {
        tag_t       tag;
        index_t     index;
        wsel_t      wsel;
        logic [1:0] byte_off;
    } addr_t;

    // Extract word <sel> of a line
    function automatic word_t get_word(input line_t line, input wsel_t sel);
        return line[32'(sel) * WORD_W +: WORD_W];
    endfunction

    // Return <line> with word <sel> replaced by <word>
    function automatic line_t put_word(input line_t line, input wsel_t sel, input word_t word);
        line_t r;
        r = line;
        r[32'(sel) * WORD_W +: WORD_W] = word;
        return r;
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data cache.
//   cpu_*  : EX/MEM request in, load data and pipeline stall out.
//   mem_*  : block-wide off-chip port (enable/write/addr/data out, refill data + ack in).
//   slave  : the cache controller's view; master : the pipeline/memory environment.
interface dcache_controller_if;
    import dcache_controller_pkg::*;

    logic [ADDR_W-1:0]     cpu_addr_i;
    logic [WORD_W-1:0]     cpu_data_i;
    logic                  cpu_read_i;
    logic                  cpu_write_i;
    logic [WORD_W-1:0]     cpu_data_o;
    logic                  stall_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i, mem_data_i, mem_ack_i,
        output cpu_data_o, stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

endinterface

// File: rtl/dcache_controller_sram.sv
// Line storage for the data cache: valid/dirty/tag/data per line.
//   rd_index_i -> rd_*_c : combinational read of one line.
//   we_i/wr_*_i          : whole-line write at the clock edge; every write leaves the line valid.
//   Only valid/dirty are reset; tag/data are don't-care while the line is invalid.
module dcache_controller_sram
    import dcache_controller_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  index_t rd_index_i,
    output logic   rd_valid_c,
    output logic   rd_dirty_c,
    output tag_t   rd_tag_c,
    output line_t  rd_line_c,
    input  logic   we_i,
    input  index_t wr_index_i,
    input  logic   wr_dirty_i,
    input  tag_t   wr_tag_i,
    input  line_t  wr_line_i
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    tag_t             tag_q  [LINES];
    tag_t             tag_d  [LINES];
    line_t            data_q [LINES];
    line_t            data_d [LINES];

    // Read port
    assign rd_valid_c = valid_q[rd_index_i];
    assign rd_dirty_c = dirty_q[rd_index_i];
    assign rd_tag_c   = tag_q[rd_index_i];
    assign rd_line_c  = data_q[rd_index_i];

    // Write port next-state
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we_i) begin
            valid_d[wr_index_i] = 1'b1;
            dirty_d[wr_index_i] = wr_dirty_i;
            tag_d[wr_index_i]   = wr_tag_i;
            data_d[wr_index_i]  = wr_line_i;
        end
    end

    // Line state flops
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
//   clk_i, rst_n_i : clock (rising edge), asynchronous active-low reset.
//   bus (slave)    : cpu_* request/response and stall, mem_* block port to off-chip memory.
// Hits complete in the request cycle with no stall. A miss raises stall_o immediately,
// writes back a dirty victim (WB), refills the line (REFILL), merges a pending store
// (DONE) and returns to IDLE where the request then hits. mem_* outputs are registered.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    dcache_controller_if.slave bus
);

    state_e            state_q, state_d;
    addr_t             req_addr_q, req_addr_d;
    word_t             req_data_q, req_data_d;
    logic              req_write_q, req_write_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    line_t             mem_data_q, mem_data_d;

    addr_t  cpu_addr;
    logic   req;
    logic   hit;
    index_t rd_index;
    logic   rd_valid;
    logic   rd_dirty;
    tag_t   rd_tag;
    line_t  rd_line;
    logic   we;
    logic   wr_dirty;
    tag_t   wr_tag;
    line_t  wr_line;
    logic   unused_byte_off;

    assign cpu_addr        = addr_t'(bus.cpu_addr_i);
    assign req             = bus.cpu_read_i | bus.cpu_write_i;
    assign unused_byte_off = ^{cpu_addr.byte_off, req_addr_q.byte_off};

    // While a miss is in flight the array is addressed by the latched request
    assign rd_index = (state_q == IDLE) ? cpu_addr.index : req_addr_q.index;
    assign hit      = rd_valid && (rd_tag == cpu_addr.tag);

    dcache_controller_sram u_sram (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_index_i (rd_index),
        .rd_valid_c (rd_valid),
        .rd_dirty_c (rd_dirty),
        .rd_tag_c   (rd_tag),
        .rd_line_c  (rd_line),
        .we_i       (we),
        .wr_index_i (rd_index),
        .wr_dirty_i (wr_dirty),
        .wr_tag_i   (wr_tag),
        .wr_line_i  (wr_line)
    );

    // Combinational CPU response
    assign bus.stall_o    = (state_q == IDLE) ? (req && !hit) : 1'b1;
    assign bus.cpu_data_o = ((state_q == IDLE) && hit) ? get_word(rd_line, cpu_addr.wsel) : '0;

    // Array updates: store hit, refill, store merge after refill
    always_comb begin
        we       = 1'b0;
        wr_dirty = 1'b0;
        wr_tag   = rd_tag;
        wr_line  = rd_line;
        unique case (state_q)
            IDLE: begin
                if (hit && bus.cpu_write_i) begin
                    we       = 1'b1;
                    wr_dirty = 1'b1;
                    wr_line  = put_word(rd_line, cpu_addr.wsel, bus.cpu_data_i);
                end
            end
            REFILL: begin
                if (bus.mem_ack_i) begin
                    we       = 1'b1;
                    wr_dirty = 1'b0;
                    wr_tag   = req_addr_q.tag;
                    wr_line  = bus.mem_data_i;
                end
            end
            DONE: begin
                if (req_write_q) begin
                    we       = 1'b1;
                    wr_dirty = 1'b1;
                    wr_line  = put_word(rd_line, req_addr_q.wsel, req_data_q);
                end
            end
            default: ;
        endcase
    end

    // Miss FSM next state; mem outputs are derived from the state being entered
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_write_d  = req_write_q;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_data_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    req_addr_d  = cpu_addr;
                    req_data_d  = bus.cpu_data_i;
                    req_write_d = bus.cpu_write_i;
                    state_d     = (rd_valid && rd_dirty) ? WB : REFILL;
                end
            end
            WB: begin
                if (bus.mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_ack_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Victim line stays addressed throughout WB, so tag/data can come straight from the array
        unique case (state_d)
            WB: begin
                mem_enable_d = 1'b1;
                mem_write_d  = 1'b1;
                mem_addr_d   = {rd_tag, req_addr_d.index, OFFSET_W'(0)};
                mem_data_d   = rd_line;
            end
            REFILL: begin
                mem_enable_d = 1'b1;
                mem_addr_d   = {req_addr_d.tag, req_addr_d.index, OFFSET_W'(0)};
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_write_q  <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_write_q  <= req_write_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Randomised self-checking bench for dcache_controller against a cache/memory reference model.
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_controller_if bus ();

    dcache_controller dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] backing [int unsigned];
    bit          m_valid [32];
    bit          m_dirty [32];
    int unsigned m_tag   [32];
    logic [31:0] m_data  [32][8];

    bit           exp_hit, exp_wb;
    logic [31:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
    logic [255:0] exp_wb_line;

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        if (backing.exists(wa)) return backing[wa];
        return (32'(wa) * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [255:0] block_rd(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_rd((base >> 2) + 32'(k));
        return l;
    endfunction

    task automatic model_access(input logic [31:0] a, input logic [31:0] d, input bit wr);
        int unsigned idx, tg, w;
        idx = (a >> 5) & 32'd31;
        tg  = a >> 10;
        w   = (a >> 2) & 32'd7;
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = 1'b0;
        if (!exp_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wb      = 1'b1;
                exp_wb_addr = (m_tag[idx] << 10) | (idx << 5);
                for (int k = 0; k < 8; k++) begin
                    exp_wb_line[k*32 +: 32] = m_data[idx][k];
                    backing[(exp_wb_addr >> 2) + 32'(k)] = m_data[idx][k];
                end
            end
            exp_fill_addr = a & 32'hFFFF_FFE0;
            for (int k = 0; k < 8; k++) m_data[idx][k] = mem_rd((exp_fill_addr >> 2) + 32'(k));
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (wr) begin
            m_data[idx][w] = d;
            m_dirty[idx]   = 1'b1;
        end
        exp_rdata = m_data[idx][w];
    endtask

    // ---------------- memory responder ----------------
    int           resp_lat  = 1;
    int           resp_cnt  = 0;
    bit           resp_busy = 1'b0;
    logic         resp_ack  = 1'b0;
    logic         inj_ack   = 1'b0;
    logic [255:0] resp_data = '0;
    logic [31:0]  log_addr [$];
    bit           log_wr   [$];
    logic [255:0] log_data [$];

    assign bus.mem_ack_i  = resp_ack | inj_ack;
    assign bus.mem_data_i = resp_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            resp_ack  = 1'b0;
            resp_busy = 1'b0;
        end else begin
            if (resp_ack) begin
                resp_ack  = 1'b0;
                resp_busy = 1'b0;
            end
            if (!resp_busy && bus.mem_enable_o) begin
                resp_busy = 1'b1;
                resp_cnt  = resp_lat;
                log_addr.push_back(bus.mem_addr_o);
                log_wr.push_back(bus.mem_write_o);
                log_data.push_back(bus.mem_data_o);
            end else if (resp_busy) begin
                resp_cnt--;
                if (resp_cnt <= 0) begin
                    resp_ack  = 1'b1;
                    resp_data = bus.mem_write_o ? '0 : block_rd(bus.mem_addr_o);
                end
            end
        end
    end

    // ---------------- CPU access ----------------
    task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                          input int lat, input string nm);
        int cyc;
        int ntx;
        model_access(a, d, wr);
        resp_lat = lat;
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
        @(negedge clk);
        bus.cpu_addr_i  = a;
        bus.cpu_data_i  = d;
        bus.cpu_read_i  = rd;
        bus.cpu_write_i = wr;
        #1;
        check_eq({nm, ".stall"}, 256'(bus.stall_o), 256'(!exp_hit));
        if (!exp_hit) begin
            cyc = 1;
            while (bus.stall_o === 1'b1 && cyc < 400) begin
                @(negedge clk);
                #1;
                if (bus.stall_o === 1'b1) cyc++;
            end
            check_eq({nm, ".timeout"}, 256'(cyc >= 400), 256'(0));
            if (!exp_wb) check_eq({nm, ".lat"}, 256'(cyc), 256'(lat + 3));
            ntx = exp_wb ? 2 : 1;
            check_eq({nm, ".ntxn"}, 256'(log_addr.size()), 256'(ntx));
            if (log_addr.size() == ntx) begin
                if (exp_wb) begin
                    check_eq({nm, ".wb_wr"}, 256'(log_wr[0]), 256'(1));
                    check_eq({nm, ".wb_addr"}, 256'(log_addr[0]), 256'(exp_wb_addr));
                    check_eq({nm, ".wb_data"}, log_data[0], exp_wb_line);
                end
                check_eq({nm, ".fill_wr"}, 256'(log_wr[ntx-1]), 256'(0));
                check_eq({nm, ".fill_addr"}, 256'(log_addr[ntx-1]), 256'(exp_fill_addr));
            end
        end
        if (rd && !wr) check_eq({nm, ".rdata"}, 256'(bus.cpu_data_o), 256'(exp_rdata));
        @(posedge clk);
        @(negedge clk);
        bus.cpu_read_i  = 1'b0;
        bus.cpu_write_i = 1'b0;
        #1;
        check_eq({nm, ".idle_en"}, 256'(bus.mem_enable_o), 256'(0));
        check_eq({nm, ".idle_stall"}, 256'(bus.stall_o), 256'(0));
    endtask

    task automatic rand_access(input int n, input string nm);
        logic [31:0] a;
        int unsigned tg, idx, w, op;
        for (int i = 0; i < n; i++) begin
            tg  = $urandom_range(0, 3);
            idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 28 + $urandom_range(0, 3);
            w   = $urandom_range(0, 7);
            op  = $urandom_range(0, 3);
            a   = (tg << 10) | (idx << 5) | (w << 2);
            access(a, $urandom, (op != 2), (op >= 2), $urandom_range(1, 6), nm);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra;
        int unsigned ridx;
        rst_n           = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_data_i  = '0;
        bus.cpu_read_i  = 1'b0;
        bus.cpu_write_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst.stall", 256'(bus.stall_o), 256'(0));
        check_eq("rst.en", 256'(bus.mem_enable_o), 256'(0));
        check_eq("rst.wr", 256'(bus.mem_write_o), 256'(0));
        check_eq("rst.addr", 256'(bus.mem_addr_o), 256'(0));
        check_eq("rst.data", bus.mem_data_o, 256'(0));
        check_eq("rst.cpu_data", 256'(bus.cpu_data_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        access(32'h0000_0040, 32'h0, 1'b1, 1'b0, 10, "t1_cold_rd");
        access(32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, 3, "t2_wr_hit");
        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, 3, "t2_rd");
        access(32'h0000_0440, 32'h0, 1'b1, 1'b0, 4, "t3_evict");
        access(32'h0000_0040, 32'h0, 1'b1, 1'b0, 2, "t3_clean");
        access(32'h0000_0080, 32'h1234_5678, 1'b0, 1'b1, 5, "t4_wr_miss");
        access(32'h0000_0080, 32'h0, 1'b1, 1'b0, 2, "t4_rd");
        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, 2, "t5_fetch");
        access(32'h0000_0044, 32'h0000_0001, 1'b1, 1'b1, 2, "t5_rdwr");
        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, 2, "t5_rd");
        access(32'h0000_07E0, 32'hCAFE_0001, 1'b0, 1'b1, 2, "wrap_wr");
        access(32'h0000_0BE4, 32'h0, 1'b1, 1'b0, 3, "wrap_evict");
        access(32'h0000_07E0, 32'h0, 1'b1, 1'b0, 1, "wrap_back");

        rand_access(200, "rnd");

        // Reset in the middle of a refill, then a stray ack
        ridx = 0;
        for (int i = 0; i < 32; i++) if (!(m_valid[i] && m_dirty[i])) ridx = 32'(i);
        ra = (32'd9 << 10) | (ridx << 5) | 32'd4;
        resp_lat = 50;
        @(negedge clk);
        bus.cpu_addr_i = ra;
        bus.cpu_read_i = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_eq("t6.refill_en", 256'(bus.mem_enable_o), 256'(1));
        check_eq("t6.refill_addr", 256'(bus.mem_addr_o), 256'(ra & 32'hFFFF_FFE0));
        @(negedge clk);
        rst_n          = 1'b0;
        bus.cpu_read_i = 1'b0;
        #1;
        check_eq("t6.rst_stall", 256'(bus.stall_o), 256'(0));
        check_eq("t6.rst_en", 256'(bus.mem_enable_o), 256'(0));
        check_eq("t6.rst_addr", 256'(bus.mem_addr_o), 256'(0));
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        #1;
        check_eq("t6.ack_stall", 256'(bus.stall_o), 256'(0));
        check_eq("t6.ack_en", 256'(bus.mem_enable_o), 256'(0));
        access(ra, 32'h0, 1'b1, 1'b0, 3, "t6_remiss");

        rand_access(40, "rnd_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
